mem_byte_lane: RTL and testbench
================================

// Module: mem_byte_lane
// PURPOSE
//   Byte-addressed synchronous RAM with a multi-byte access port.
//   One address selects DATA_WIDTH_BYTES consecutive bytes.
//   Each byte lane has its own active-low write enable and registered read data.
//   Serves as the unified instruction/data store of the core; one access per clock.
// PARAMETERS
//   DATA_WIDTH_BYTES  4     bytes per access (lanes 0..DATA_WIDTH_BYTES-1)
//   ADDR_WIDTH        12    byte-address width
//   MEM_SIZE_BYTES    4096  storage depth in bytes; must equal 2**ADDR_WIDTH
// PORTS
//   clk       in   1                   single clock, all activity on rising edge
//   rstL      in   1                   synchronous, active-high reset (1 = reset)
//   wenableL  in   1 x DATA_WIDTH_BYTES   per-lane write enable, active-low, unpacked [0:N-1]
//   data_w    in   8 x DATA_WIDTH_BYTES   write bytes, unpacked [0:N-1] of [7:0]
//   addr      in   ADDR_WIDTH          byte address of lane 0
//   data_r    out  8 x DATA_WIDTH_BYTES   read bytes, unpacked [0:N-1] of [7:0]
// BEHAVIOUR
//   - Lane mapping: lane k <-> byte mem[(addr+k) mod MEM_SIZE_BYTES].
//     data_w[0]/data_r[0] is the byte at addr (lowest address first).
//   - Any addr is legal; no alignment requirement. Lane addresses wrap past MEM_SIZE_BYTES-1 to 0.
//   - Reset: on a rising edge with rstL=1, data_r[k] <= 8'h00 for all k.
//     No writes occur on that edge. Storage contents are not cleared (undefined after power-up).
//   - Write: on a rising edge with rstL=0, mem[(addr+k)] <= data_w[k] for every k with wenableL[k]=0.
//     Lanes with wenableL[k]=1 leave storage unchanged.
//   - Read: on every rising edge with rstL=0, data_r[k] <= mem[(addr+k)], 1-cycle latency.
//     Reads happen regardless of wenableL. data_r holds between edges.
//   - Read-during-write, same edge/same byte: data_r returns the OLD byte.
//     The new byte is visible from the next edge's read.
//   - Lanes are independent: mixed enable patterns (e.g. 4'b0101) are legal.
//   - Reset asserted mid-operation: the pending edge performs no write and zeroes data_r.
//     Normal operation resumes on the first edge with rstL=0.
//   - X/Z on wenableL[k] is treated as no-write; no assertions inside the RTL.
// TESTING
//   1. rstL=1 one edge -> data_r = 00 00 00 00. Release rstL=0, all wenableL=1 -> no storage change.
//   2. addr=0x000, data_w={11,22,33,44}, wenableL=0000 one edge; then wenableL=1111, addr=0x000
//      -> data_r={11,22,33,44} one edge later.
//   3. Preload 0x100..0x103={AA,BB,CC,DD}; write {01,02,03,04} with wenableL={1,0,1,0} (lanes 1,3 enabled)
//      -> readback {AA,02,CC,04}.
//   4. Wrap: addr=0xFFE, write {5A,5B,5C,5D} -> bytes 0xFFE=5A, 0xFFF=5B, 0x000=5C, 0x001=5D.
//      Read addr=0x000 returns {5C,5D,..}.
//   5. Read-during-write: 0x010 holds {01,02,03,04}; write {F0,F1,F2,F3} to 0x010
//      -> data_r after that edge = {01,02,03,04}; after the next edge = {F0,F1,F2,F3}.
//   6. Sweep: write 4 bytes at addr=i, i=0,4,...,4092, pattern byte = address[7:0]; then read all back
//      -> every byte equals its address[7:0]. Assert rstL=1 mid-sweep -> that write dropped and data_r=0.

Source files
------------

// File: rtl/mem_byte_lane_if.sv
// rtl/mem_byte_lane_if.sv - multi-byte access port of the byte-lane RAM
// Lane 0 is the byte at addr; higher lanes follow at increasing addresses.
interface mem_byte_lane_if #(
    parameter int DATA_WIDTH_BYTES = 4,
    parameter int ADDR_WIDTH       = 12
);
    logic                  wenableL [0:DATA_WIDTH_BYTES-1];
    logic [7:0]            data_w   [0:DATA_WIDTH_BYTES-1];
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            data_r   [0:DATA_WIDTH_BYTES-1];

    modport master (
        output wenableL,
        output data_w,
        output addr,
        input  data_r
    );

    modport slave (
        input  wenableL,
        input  data_w,
        input  addr,
        output data_r
    );
endinterface

// File: rtl/mem_byte_lane.sv
// rtl/mem_byte_lane.sv - byte-addressed synchronous RAM with per-lane write enables
// Unaligned accesses wrap modulo the memory size; reads return pre-write data.
module mem_byte_lane #(
    parameter int DATA_WIDTH_BYTES = 4,
    parameter int ADDR_WIDTH       = 12,
    parameter int MEM_SIZE_BYTES   = 4096
) (
    input  logic             clk,
    input  logic             rstL,
    mem_byte_lane_if.slave   bus
);
    logic [7:0]            r_mem      [0:MEM_SIZE_BYTES-1];
    logic [7:0]            r_data_r   [0:DATA_WIDTH_BYTES-1];
    logic [ADDR_WIDTH-1:0] w_lane_addr [0:DATA_WIDTH_BYTES-1];

    // Truncation to ADDR_WIDTH gives the wrap, since the depth is 2**ADDR_WIDTH.
    always_comb begin
        for (int k = 0; k < DATA_WIDTH_BYTES; k++) begin
            w_lane_addr[k] = bus.addr + ADDR_WIDTH'(k);
        end
    end

    // Storage is never cleared; an X/Z enable falls to the no-write branch.
    always_ff @(posedge clk) begin
        if (!rstL) begin
            for (int k = 0; k < DATA_WIDTH_BYTES; k++) begin
                if (!bus.wenableL[k]) begin
                    r_mem[w_lane_addr[k]] <= bus.data_w[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rstL) begin
            for (int k = 0; k < DATA_WIDTH_BYTES; k++) begin
                r_data_r[k] <= 8'h00;
            end
        end else begin
            for (int k = 0; k < DATA_WIDTH_BYTES; k++) begin
                r_data_r[k] <= r_mem[w_lane_addr[k]];
            end
        end
    end

    for (genvar g = 0; g < DATA_WIDTH_BYTES; g++) begin : g_lane_out
        assign bus.data_r[g] = r_data_r[g];
    end
endmodule

// File: tb/tb_mem_byte_lane.sv
// tb/tb_mem_byte_lane.sv - directed self-checking bench for mem_byte_lane
module tb_mem_byte_lane;
    logic clk;
    logic rstL;
    int   n_checks;
    int   n_fail;

    mem_byte_lane_if #(.DATA_WIDTH_BYTES(4), .ADDR_WIDTH(12)) bus ();

    mem_byte_lane #(
        .DATA_WIDTH_BYTES(4),
        .ADDR_WIDTH(12),
        .MEM_SIZE_BYTES(4096)
    ) dut (
        .clk  (clk),
        .rstL (rstL),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Lane 0 sits in the most significant byte of every 32-bit word below.
    function automatic logic [31:0] rd();
        return {bus.data_r[0], bus.data_r[1], bus.data_r[2], bus.data_r[3]};
    endfunction

    task automatic drive(input logic [11:0] a, input logic [31:0] d, input logic [3:0] wen_l0_first);
        bus.addr        = a;
        bus.data_w[0]   = d[31:24];
        bus.data_w[1]   = d[23:16];
        bus.data_w[2]   = d[15:8];
        bus.data_w[3]   = d[7:0];
        bus.wenableL[0] = wen_l0_first[3];
        bus.wenableL[1] = wen_l0_first[2];
        bus.wenableL[2] = wen_l0_first[1];
        bus.wenableL[3] = wen_l0_first[0];
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]  b;
        logic [31:0] exp;
        logic [11:0] a;
        n_checks = 0;
        n_fail   = 0;

        // Reset zeroes data_r
        rstL = 1'b1;
        drive(12'h000, 32'h0, 4'b1111);
        cycle();
        check_eq("reset_data_r", rd(), 32'h0000_0000);
        cycle();
        check_eq("reset_hold", rd(), 32'h0000_0000);
        rstL = 1'b0;
        drive(12'h000, 32'hDEAD_BEEF, 4'b1111);
        cycle();

        // Full-word write then read
        drive(12'h000, 32'h1122_3344, 4'b0000);
        cycle();
        drive(12'h000, 32'h0, 4'b1111);
        cycle();
        check_eq("full_write_read", rd(), 32'h1122_3344);
        cycle();
        check_eq("read_hold", rd(), 32'h1122_3344);

        // Mixed lane enables: lanes 1 and 3 written
        drive(12'h100, 32'hAABB_CCDD, 4'b0000);
        cycle();
        drive(12'h100, 32'h0102_0304, 4'b1010);
        cycle();
        check_eq("partial_rdw_old", rd(), 32'hAABB_CCDD);
        drive(12'h100, 32'h0, 4'b1111);
        cycle();
        check_eq("partial_lanes", rd(), 32'hAA02_CC04);
        drive(12'h100, 32'h7777_7777, 4'b0101);
        cycle();
        drive(12'h100, 32'h0, 4'b1111);
        cycle();
        check_eq("partial_lanes_0_2", rd(), 32'h7702_7704);
        drive(12'h100, 32'hAA02_CC04, 4'b0000);
        cycle();

        // Wrap past the top of memory
        drive(12'hFFE, 32'h5A5B_5C5D, 4'b0000);
        cycle();
        drive(12'hFFE, 32'h0, 4'b1111);
        cycle();
        check_eq("wrap_read_ffe", rd(), 32'h5A5B_5C5D);
        drive(12'h000, 32'h0, 4'b1111);
        cycle();
        check_eq("wrap_read_000", rd(), 32'h5C5D_3344);
        drive(12'hFFF, 32'h0, 4'b1111);
        cycle();
        check_eq("wrap_read_fff", rd(), 32'h5B5C_5D33);

        // Read-during-write returns old bytes
        drive(12'h010, 32'h0102_0304, 4'b0000);
        cycle();
        drive(12'h010, 32'hF0F1_F2F3, 4'b0000);
        cycle();
        check_eq("rdw_old", rd(), 32'h0102_0304);
        drive(12'h010, 32'h0, 4'b1111);
        cycle();
        check_eq("rdw_new", rd(), 32'hF0F1_F2F3);

        // Sweep with reset asserted on the 0x100 write
        for (int i = 0; i < 4096; i += 4) begin
            a = 12'(i);
            b = a[7:0];
            drive(a, {b, b + 8'd1, b + 8'd2, b + 8'd3}, 4'b0000);
            if (i == 'h100) begin
                rstL = 1'b1;
                cycle();
                check_eq("mid_sweep_reset", rd(), 32'h0000_0000);
                rstL = 1'b0;
            end else begin
                cycle();
            end
        end
        for (int i = 0; i < 4096; i += 4) begin
            a = 12'(i);
            b = a[7:0];
            drive(a, 32'h0, 4'b1111);
            cycle();
            exp = (i == 'h100) ? 32'hAA02_CC04 : {b, b + 8'd1, b + 8'd2, b + 8'd3};
            check_eq($sformatf("sweep_%03h", a), rd(), exp);
        end
        drive(12'hFFE, 32'h0, 4'b1111);
        cycle();
        check_eq("sweep_wrap_ffe", rd(), 32'hFEFF_0001);
        drive(12'h0FE, 32'h0, 4'b1111);
        cycle();
        check_eq("sweep_unaligned_0fe", rd(), 32'hFEFF_AA02);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
